tt_scanner: RTL and testbench

Sequential truth-table extractor that drives the input side of a 4-input combinational function unit and reads back its output.
- Sweeps the select vector a_out over every code from 0 to 2^WIDTH-1.
- Waits a programmable settle time per vector, then samples the unit's response.
- Builds an ON-set mask and a don't-care mask, so the truth table of any function block can be captured and checked on-chip.

---
 rtl/tt_scanner.sv | 112 +++++++++++
 tb/tb_tt_scanner.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/tt_scanner.sv
// Truth-table scanner: sweeps a_out over all codes, samples f_in after a settle delay and builds ON/DC masks.
// Optional build macro TT_ZPROBE_EN: sim-only classification of a high-Z/X f_in as don't-care (f_drv ignored).
module tt_scanner #(
  parameter int WIDTH  = 4,
  parameter int SETTLE = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    f_in,
  input  logic                    f_drv,
  output logic [WIDTH-1:0]        a_out,
  output logic                    busy,
  output logic                    done,
  output logic [(1<<WIDTH)-1:0]   on_mask,
  output logic [(1<<WIDTH)-1:0]   dc_mask
);

  localparam int MW = 1 << WIDTH;
  localparam logic [3:0]       SETTLE_LD = 4'(SETTLE);
  localparam logic [WIDTH-1:0] A_LAST    = '1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_SAMPLE,
    S_FIN
  } state_t;

  // With no settle time each vector goes straight to its sample cycle.
  localparam state_t VEC_ENTRY = (SETTLE == 0) ? S_SAMPLE : S_SETTLE;

  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [MW-1:0]    on_q, on_d;
  logic [MW-1:0]    dc_q, dc_d;
  logic             samp_on, samp_dc;

  always_comb begin
`ifdef TT_ZPROBE_EN
    samp_dc = (f_in === 1'bz) || (f_in === 1'bx);
    samp_on = !samp_dc && (f_in === 1'b1);
`else
    samp_dc = !f_drv;
    samp_on = f_drv && f_in;
`endif
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    on_d    = on_q;
    dc_d    = dc_q;
    case (state_q)
      S_IDLE, S_FIN: begin
        if (start) begin
          state_d = VEC_ENTRY;
          cnt_d   = SETTLE_LD;
          a_d     = '0;
          on_d    = '0;
          dc_d    = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SETTLE: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d = S_SAMPLE;
        end
      end
      S_SAMPLE: begin
        if (samp_on) on_d[a_q] = 1'b1;
        if (samp_dc) dc_d[a_q] = 1'b1;
        // The sweep stops at the all-ones code; a_out never wraps.
        if (a_q == A_LAST) begin
          state_d = S_FIN;
        end else begin
          a_d     = a_q + 1'b1;
          cnt_d   = SETTLE_LD;
          state_d = VEC_ENTRY;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      on_q    <= '0;
      dc_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      on_q    <= on_d;
      dc_q    <= dc_d;
    end
  end

  assign a_out   = a_q;
  assign busy    = (state_q == S_SETTLE) || (state_q == S_SAMPLE);
  assign done    = (state_q == S_FIN);
  assign on_mask = on_q;
  assign dc_mask = dc_q;

endmodule

// File: tb/tb_tt_scanner.sv
// Directed bench for tt_scanner: one instance with SETTLE=1, one with SETTLE=0.
module tb_tt_scanner;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_a, start_b;
  logic        f_in_a, f_drv_a;
  logic        f_in_b, f_drv_b;
  logic [3:0]  a_out_a, a_out_b;
  logic        busy_a, busy_b, done_a, done_b;
  logic [15:0] on_a, dc_a, on_b, dc_b;

  logic [15:0] cur_on, cur_dc;
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  tt_scanner #(.WIDTH(4), .SETTLE(1)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .f_in(f_in_a), .f_drv(f_drv_a),
    .a_out(a_out_a), .busy(busy_a), .done(done_a), .on_mask(on_a), .dc_mask(dc_a)
  );

  tt_scanner #(.WIDTH(4), .SETTLE(0)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .f_in(f_in_b), .f_drv(f_drv_b),
    .a_out(a_out_b), .busy(busy_b), .done(done_b), .on_mask(on_b), .dc_mask(dc_b)
  );

  // Behavioural function unit for dut_a; don't-care codes present f_in=1 so ignoring it is exercised.
  always_comb begin
`ifdef TT_ZPROBE_EN
    f_drv_a = 1'b1;
    f_in_a  = cur_dc[a_out_a] ? 1'bz : cur_on[a_out_a];
`else
    f_drv_a = !cur_dc[a_out_a];
    f_in_a  = cur_on[a_out_a] | cur_dc[a_out_a];
`endif
  end

  assign f_in_b  = 1'b1;
  assign f_drv_b = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // One sweep on dut_a with optional extra start pulses and a mid-sweep reset.
  task automatic sweep_a(input int pulse1, input int pulse2, input int rst_at, input int max_cyc,
                         output int first_done, output int n_done);
    int cyc;
    @(negedge clk);
    start_a = 1'b1;
    @(posedge clk);
    cyc = 0;
    first_done = -1;
    n_done = 0;
    while (cyc < max_cyc) begin
      @(negedge clk);
      cyc++;
      start_a = (cyc == pulse1) || (cyc == pulse2);
      if (cyc == rst_at) begin
        rst = 1'b1;
        #1;
        check("rst_busy", 32'(busy_a), 32'd0);
        check("rst_done", 32'(done_a), 32'd0);
        check("rst_aout", 32'(a_out_a), 32'd0);
        check("rst_on",   32'(on_a), 32'd0);
        check("rst_dc",   32'(dc_a), 32'd0);
      end
      if (rst_at > 0 && cyc == rst_at + 2) rst = 1'b0;
      if (done_a) begin
        n_done++;
        if (first_done < 0) first_done = cyc;
      end
      check("invariant", 32'(on_a & dc_a), 32'd0);
    end
    start_a = 1'b0;
  endtask

  typedef struct {
    string       name;
    logic [15:0] on_set;
    logic [15:0] dc_set;
    logic [15:0] exp_on;
    logic [15:0] exp_dc;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int fd, nd, cyc, fd2;
    vecs[0] = '{"plan1",   16'b1100_0000_1001_0000, 16'b0000_1100_0010_0000, 16'hC090, 16'h0C20};
    vecs[1] = '{"all_on",  16'hFFFF, 16'h0000, 16'hFFFF, 16'h0000};
    vecs[2] = '{"all_off", 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    vecs[3] = '{"all_dc",  16'h0000, 16'hFFFF, 16'h0000, 16'hFFFF};
    vecs[4] = '{"mixed",   16'b1010_1010_1010_0000, 16'b0000_0000_0000_0101, 16'hAAA0, 16'h0005};

    rst = 1'b1;
    start_a = 1'b0;
    start_b = 1'b0;
    cur_on = '0;
    cur_dc = '0;
    repeat (2) @(negedge clk);
    check("reset_aout", 32'(a_out_a), 32'd0);
    check("reset_busy", 32'(busy_a), 32'd0);
    check("reset_done", 32'(done_a), 32'd0);
    check("reset_on",   32'(on_a), 32'd0);
    check("reset_dc",   32'(dc_a), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      cur_on = vecs[i].on_set;
      cur_dc = vecs[i].dc_set;
      sweep_a(-1, -1, -1, 40, fd, nd);
      check({vecs[i].name, "_done_cyc"}, 32'(fd), 32'd33);
      check({vecs[i].name, "_ndone"},    32'(nd), 32'd1);
      check({vecs[i].name, "_on"},       32'(on_a), 32'(vecs[i].exp_on));
      check({vecs[i].name, "_dc"},       32'(dc_a), 32'(vecs[i].exp_dc));
      check({vecs[i].name, "_aout"},     32'(a_out_a), 32'd15);
      check({vecs[i].name, "_busy"},     32'(busy_a), 32'd0);
    end

    // SETTLE=0 instance: one vector per cycle
    @(negedge clk);
    start_b = 1'b1;
    @(posedge clk);
    cyc = 0;
    fd = -1;
    nd = 0;
    while (cyc < 30) begin
      @(negedge clk);
      cyc++;
      start_b = 1'b0;
      if (cyc <= 16) check("b_aout_step", 32'(a_out_b), 32'(cyc - 1));
      if (done_b) begin
        nd++;
        if (fd < 0) fd = cyc;
      end
    end
    check("b_done_cyc", 32'(fd), 32'd17);
    check("b_ndone",    32'(nd), 32'd1);
    check("b_on",       32'(on_b), 32'hFFFF);
    check("b_dc",       32'(dc_b), 32'd0);

    // start pulses during a running sweep are ignored
    cur_on = vecs[0].on_set;
    cur_dc = vecs[0].dc_set;
    sweep_a(5, 20, -1, 45, fd, nd);
    check("ign_done_cyc", 32'(fd), 32'd33);
    check("ign_ndone",    32'(nd), 32'd1);
    check("ign_on",       32'(on_a), 32'hC090);
    check("ign_dc",       32'(dc_a), 32'h0C20);

    // reset at cycle 12 aborts with no done, then a clean sweep
    sweep_a(-1, -1, 12, 40, fd, nd);
    check("abort_ndone", 32'(nd), 32'd0);
    check("abort_busy",  32'(busy_a), 32'd0);
    sweep_a(-1, -1, -1, 40, fd, nd);
    check("post_rst_done_cyc", 32'(fd), 32'd33);
    check("post_rst_on",       32'(on_a), 32'hC090);
    check("post_rst_dc",       32'(dc_a), 32'h0C20);

    // start held in FIN restarts directly
    @(negedge clk);
    start_a = 1'b1;
    @(posedge clk);
    cyc = 0;
    fd = -1;
    fd2 = -1;
    while (cyc < 80 && fd2 < 0) begin
      @(negedge clk);
      cyc++;
      start_a = 1'b0;
      if (done_a) begin
        if (fd < 0) begin
          fd = cyc;
          start_a = 1'b1;
        end else begin
          fd2 = cyc;
        end
      end
      if (fd > 0 && cyc == fd + 1) begin
        check("restart_busy", 32'(busy_a), 32'd1);
        check("restart_aout", 32'(a_out_a), 32'd0);
        check("restart_on",   32'(on_a), 32'd0);
        check("restart_dc",   32'(dc_a), 32'd0);
      end
    end
    start_a = 1'b0;
    check("fin_done1_cyc", 32'(fd), 32'd33);
    check("fin_done2_cyc", 32'(fd2), 32'd66);
    check("fin_on",        32'(on_a), 32'hC090);
    check("fin_dc",        32'(dc_a), 32'h0C20);
    @(negedge clk);
    check("idle_after_fin", 32'({busy_a, done_a}), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
